// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and the 12-hour display mapping for rtc_counter.
//   HR12_OFFSET   hours subtracted for afternoon values in 12-hour form
//   disp12_t      12-hour display value plus PM flag
//   to_12h()      maps a 24-hour value (0..DAY_HRS-1) to disp12_t
package rtc_pkg;

    localparam int HR_MAX_W = 8;
    localparam logic [HR_MAX_W-1:0] HR12_OFFSET = 8'd12;

    typedef struct packed {
        logic [HR_MAX_W-1:0] hour;
        logic                pm;
    } disp12_t;

    function automatic disp12_t to_12h(input logic [HR_MAX_W-1:0] hr);
        disp12_t d;
        if (hr == '0) begin
            d.hour = HR12_OFFSET;
            d.pm   = 1'b0;
        end else if (hr < HR12_OFFSET) begin
            d.hour = hr;
            d.pm   = 1'b0;
        end else if (hr == HR12_OFFSET) begin
            d.hour = HR12_OFFSET;
            d.pm   = 1'b1;
        end else begin
            d.hour = hr - HR12_OFFSET;
            d.pm   = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD up-counter with synchronous load.
//   clk, rst_n   clock, async active-low reset (q -> 0)
//   inc          count enable
//   load, ld_val synchronous load, has priority over inc
//   q            current count, 0..MOD-1
//   carry        combinational: inc while q==MOD-1 (wrap on this edge)
module mod_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         carry
);

    assign carry = inc && (q == W'(MOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= ld_val;
        else if (inc)
            q <= carry ? '0 : q + W'(1);
    end

endmodule

// File: rtl/rtc_counter.sv
// rtc_counter: real-time clock core. Divides clk by FREQ to a one-second
// advance and keeps hr:min:sec in 24-hour form, with validated loading,
// daily alarm, 12/24-hour display and registered strobes.
//   clk, rst_n                      clock, async active-low reset
//   en_i                            run enable (low freezes everything)
//   mode12_i                        1: 12-hour display with pm_o
//   set_i, set_hr/min/sec_i         load strobe and 24-hour load values
//   alm_set_i, alm_hr/min_i         alarm capture strobe and alarm time
//   alm_en_i                        alarm enable
//   sec_o, min_o, hour_o, pm_o      current time in display form
//   tick_o, day_o, alarm_o          one-cycle strobes with the new time
//   set_err_o                       one-cycle pulse after a rejected load
module rtc_counter
    import rtc_pkg::*;
#(
    parameter int FREQ    = 10,
    parameter int UNIT    = 60,
    parameter int DAY_HRS = 24,
    parameter int SEC_W   = 6,
    parameter int HR_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             mode12_i,
    input  logic             set_i,
    input  logic [HR_W-1:0]  set_hr_i,
    input  logic [SEC_W-1:0] set_min_i,
    input  logic [SEC_W-1:0] set_sec_i,
    input  logic             alm_set_i,
    input  logic [HR_W-1:0]  alm_hr_i,
    input  logic [SEC_W-1:0] alm_min_i,
    input  logic             alm_en_i,
    output logic [SEC_W-1:0] sec_o,
    output logic [SEC_W-1:0] min_o,
    output logic [HR_W-1:0]  hour_o,
    output logic             pm_o,
    output logic             tick_o,
    output logic             day_o,
    output logic             alarm_o,
    output logic             set_err_o
);

    localparam int PRE_W = (FREQ > 1) ? $clog2(FREQ) : 1;

    logic [PRE_W-1:0] pre_q;
    logic [SEC_W-1:0] sec_q, min_q, nxt_min;
    logic [HR_W-1:0]  hr_q, nxt_hr;
    logic [SEC_W-1:0] alm_min_q;
    logic [HR_W-1:0]  alm_hr_q;
    logic             adv, sec_carry, min_carry, hr_carry;
    logic             set_ok;
    disp12_t          d12;

    // Widen by one bit so the range checks hold even when the limit is 2**W.
    assign set_ok = set_i
                 && ({1'b0, set_hr_i}  < (HR_W + 1)'(DAY_HRS))
                 && ({1'b0, set_min_i} < (SEC_W + 1)'(UNIT))
                 && ({1'b0, set_sec_i} < (SEC_W + 1)'(UNIT));

    mod_counter #(.MOD(FREQ), .W(PRE_W)) u_pre (
        .clk(clk), .rst_n(rst_n), .inc(en_i), .load(set_ok),
        .ld_val('0), .q(pre_q), .carry(adv)
    );

    mod_counter #(.MOD(UNIT), .W(SEC_W)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc(adv), .load(set_ok),
        .ld_val(set_sec_i), .q(sec_q), .carry(sec_carry)
    );

    mod_counter #(.MOD(UNIT), .W(SEC_W)) u_min (
        .clk(clk), .rst_n(rst_n), .inc(sec_carry), .load(set_ok),
        .ld_val(set_min_i), .q(min_q), .carry(min_carry)
    );

    mod_counter #(.MOD(DAY_HRS), .W(HR_W)) u_hr (
        .clk(clk), .rst_n(rst_n), .inc(min_carry), .load(set_ok),
        .ld_val(set_hr_i), .q(hr_q), .carry(hr_carry)
    );

    // Post-advance min/hr, used to detect the alarm on the same edge that
    // produces the matching time so alarm_o lines up with the new outputs.
    always_comb begin
        nxt_min = min_q;
        nxt_hr  = hr_q;
        if (sec_carry)
            nxt_min = min_carry ? '0 : min_q + SEC_W'(1);
        if (min_carry)
            nxt_hr = hr_carry ? '0 : hr_q + HR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alm_hr_q  <= '0;
            alm_min_q <= '0;
            tick_o    <= 1'b0;
            day_o     <= 1'b0;
            alarm_o   <= 1'b0;
            set_err_o <= 1'b0;
        end else begin
            if (alm_set_i) begin
                alm_hr_q  <= alm_hr_i;
                alm_min_q <= alm_min_i;
            end
            // A load discards a coincident advance, so it suppresses all strobes.
            tick_o    <= adv && !set_ok;
            day_o     <= hr_carry && !set_ok;
            alarm_o   <= sec_carry && !set_ok && alm_en_i
                      && (nxt_min == alm_min_q) && (nxt_hr == alm_hr_q);
            set_err_o <= set_i && !set_ok;
        end
    end

    always_comb begin
        d12    = to_12h(HR_MAX_W'(hr_q));
        sec_o  = sec_q;
        min_o  = min_q;
        hour_o = mode12_i ? HR_W'(d12.hour) : hr_q;
        pm_o   = mode12_i & d12.pm;
    end

endmodule

// File: tb/tb_rtc_counter.sv
// tb_rtc_counter: directed self-checking bench for rtc_counter (FREQ=10,
// UNIT=60, DAY_HRS=24). Expected values are hand-computed constants.
module tb_rtc_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i = 1'b0;
    logic       mode12_i = 1'b0;
    logic       set_i = 1'b0;
    logic [4:0] set_hr_i = '0;
    logic [5:0] set_min_i = '0;
    logic [5:0] set_sec_i = '0;
    logic       alm_set_i = 1'b0;
    logic [4:0] alm_hr_i = '0;
    logic [5:0] alm_min_i = '0;
    logic       alm_en_i = 1'b0;
    logic [5:0] sec_o, min_o;
    logic [4:0] hour_o;
    logic       pm_o, tick_o, day_o, alarm_o, set_err_o;

    int tests = 0;
    int fails = 0;

    rtc_counter dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode12_i(mode12_i),
        .set_i(set_i), .set_hr_i(set_hr_i), .set_min_i(set_min_i),
        .set_sec_i(set_sec_i), .alm_set_i(alm_set_i), .alm_hr_i(alm_hr_i),
        .alm_min_i(alm_min_i), .alm_en_i(alm_en_i), .sec_o(sec_o),
        .min_o(min_o), .hour_o(hour_o), .pm_o(pm_o), .tick_o(tick_o),
        .day_o(day_o), .alarm_o(alarm_o), .set_err_o(set_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hour"}, 32'(hour_o), 32'(h));
        chk({tag, ".min"},  32'(min_o),  32'(m));
        chk({tag, ".sec"},  32'(sec_o),  32'(s));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a load for exactly one edge; outputs sampled 1 time unit after it.
    task automatic do_set(input int h, input int m, input int s);
        set_hr_i  = 5'(h);
        set_min_i = 6'(m);
        set_sec_i = 6'(s);
        set_i     = 1'b1;
        step(1);
        set_i     = 1'b0;
    endtask

    initial begin
        en_i = 1'b1;
        #22;
        chk_time("rst24", 0, 0, 0);
        chk("rst.pm", 32'(pm_o), 0);
        chk("rst.strobes", 32'({tick_o, day_o, alarm_o, set_err_o}), 0);
        mode12_i = 1'b1;
        #1;
        chk("rst.hour12", 32'(hour_o), 12);
        mode12_i = 1'b0;
        #1;
        rst_n = 1'b1;

        // First tick on the 10th edge after release.
        step(9);
        chk("pre9.tick", 32'(tick_o), 0);
        chk("pre9.sec", 32'(sec_o), 0);
        step(1);
        chk("edge10.tick", 32'(tick_o), 1);
        chk("edge10.sec", 32'(sec_o), 1);
        step(1);
        chk("edge11.tick", 32'(tick_o), 0);
        step(589);
        chk_time("edge600", 0, 1, 0);

        // Day wrap from 23:59:59.
        do_set(23, 59, 59);
        chk_time("load235959", 23, 59, 59);
        chk("load.tick", 32'(tick_o), 0);
        step(9);
        chk("wrap9.tick", 32'(tick_o), 0);
        step(1);
        chk_time("wrap", 0, 0, 0);
        chk("wrap.tick", 32'(tick_o), 1);
        chk("wrap.day", 32'(day_o), 1);
        mode12_i = 1'b1;
        #1;
        chk("wrap.hour12", 32'(hour_o), 12);
        chk("wrap.pm12", 32'(pm_o), 0);
        mode12_i = 1'b0;

        // Rejected loads leave the time alone.
        do_set(5, 60, 0);
        chk("err.min60", 32'(set_err_o), 1);
        chk_time("err.time", 0, 0, 0);
        step(1);
        chk("err.clear", 32'(set_err_o), 0);
        do_set(24, 0, 0);
        chk("err.hr24", 32'(set_err_o), 1);
        chk_time("err.time2", 0, 0, 0);
        do_set(23, 0, 59);
        chk("ok.noerr", 32'(set_err_o), 0);

        // 12-hour mapping at the boundaries.
        mode12_i = 1'b1;
        #1;
        chk("m12.23h", 32'(hour_o), 11);
        chk("m12.23pm", 32'(pm_o), 1);
        do_set(12, 0, 0);
        chk("m12.12h", 32'(hour_o), 12);
        chk("m12.12pm", 32'(pm_o), 1);
        do_set(11, 0, 0);
        chk("m12.11h", 32'(hour_o), 11);
        chk("m12.11pm", 32'(pm_o), 0);
        mode12_i = 1'b0;

        // Load landing on an advance edge wins and suppresses the tick.
        do_set(10, 20, 30);
        step(9);
        do_set(1, 2, 3);
        chk_time("ldadv", 1, 2, 3);
        chk("ldadv.tick", 32'(tick_o), 0);
        step(9);
        chk("ldadv9.tick", 32'(tick_o), 0);
        step(1);
        chk("ldadv10.tick", 32'(tick_o), 1);
        chk_time("ldadv10", 1, 2, 4);

        // Alarm capture coincident with load; alarm enabled.
        alm_hr_i  = 5'd7;
        alm_min_i = 6'd30;
        alm_set_i = 1'b1;
        alm_en_i  = 1'b1;
        do_set(7, 29, 59);
        alm_set_i = 1'b0;
        step(9);
        chk("alm9.alarm", 32'(alarm_o), 0);
        step(1);
        chk_time("alm", 7, 30, 0);
        chk("alm.alarm", 32'(alarm_o), 1);
        chk("alm.tick", 32'(tick_o), 1);
        step(1);
        chk("alm.once", 32'(alarm_o), 0);
        step(9);
        chk("alm.nextsec", 32'(alarm_o), 0);
        chk_time("alm.nextsec", 7, 30, 1);

        // Same setup with the alarm disabled.
        alm_en_i = 1'b0;
        do_set(7, 29, 59);
        step(10);
        chk_time("almoff", 7, 30, 0);
        chk("almoff.alarm", 32'(alarm_o), 0);

        // en_i low for 25 cycles mid-second delays the tick by exactly 25.
        do_set(0, 0, 0);
        step(4);
        en_i = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            chk("hold.tick", 32'(tick_o), 0);
        end
        chk_time("hold", 0, 0, 0);
        en_i = 1'b1;
        step(5);
        chk("resume5.tick", 32'(tick_o), 0);
        chk("resume5.sec", 32'(sec_o), 0);
        step(1);
        chk("resume6.tick", 32'(tick_o), 1);
        chk("resume6.sec", 32'(sec_o), 1);

        // Async reset mid-count from 13:05:42 in 12-hour mode.
        mode12_i = 1'b1;
        do_set(13, 5, 42);
        chk("pre_rst.hour12", 32'(hour_o), 1);
        chk("pre_rst.pm", 32'(pm_o), 1);
        chk_time("pre_rst", 1, 5, 42);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_time("async_rst", 12, 0, 0);
        chk("async_rst.pm", 32'(pm_o), 0);
        mode12_i = 1'b0;
        #1;
        chk("async_rst.hour24", 32'(hour_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(9);
        chk("post_rst9.tick", 32'(tick_o), 0);
        step(1);
        chk("post_rst10.tick", 32'(tick_o), 1);
        chk("post_rst10.sec", 32'(sec_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_counter.md
# rtc_counter

Parametrised real-time clock core and successor to the fixed-range digital clock. It divides the system clock down to a one-second tick and keeps hours/minutes/seconds. It adds a run enable, validated time loading, 12/24-hour output mode, a daily alarm, and tick/rollover strobes. It sits between the board clock and the display/controller logic.

## Interface
- FREQ, 10: clk cycles per second (≥2)
- UNIT, 60: seconds per minute and minutes per hour (≥2)
- DAY_HRS, 24: hours per day (even, ≥2)
- SEC_W, 6: width of second/minute fields (≥ clog2(UNIT))
- HR_W, 5: width of hour field (≥ clog2(DAY_HRS))
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  run enable; low freezes prescaler and time
- mode12_i  in  1  1: 12-hour display, 0: 24-hour display
- set_i  in  1  one-cycle load strobe
- set_hr_i / set_min_i / set_sec_i  in  HR_W / SEC_W / SEC_W  load values (24-hour form)
- alm_set_i  in  1  one-cycle alarm-capture strobe
- alm_hr_i / alm_min_i  in  HR_W / SEC_W  alarm time (24-hour form)
- alm_en_i  in  1  alarm enable
- sec_o, min_o  out  SEC_W  current second/minute
- hour_o  out  HR_W  hour in the selected display form
- pm_o  out  1  PM flag (12-hour mode only, else 0)
- tick_o  out  1  one-cycle pulse on every second advance
- day_o  out  1  one-cycle pulse on the wrap to 00:00:00
- alarm_o  out  1  one-cycle pulse on an alarm match
- set_err_o  out  1  one-cycle pulse when a load is rejected

## Operation
- Internal state: prescaler 0..FREQ-1, sec/min 0..UNIT-1, hr 0..DAY_HRS-1 (always 24-hour form), alarm hr/min registers.
- Advance: when en_i=1 and prescaler==FREQ-1, the prescaler goes to 0 and sec increments. sec==UNIT-1 wraps to 0 and carries to min; min wraps likewise and carries to hr; hr==DAY_HRS-1 wraps to 0 and asserts day_o.
- When en_i=1 and no advance occurs, the prescaler increments. When en_i=0, all counters hold and no strobes fire.
- Load: on set_i, if set_hr_i<DAY_HRS, set_min_i<UNIT and set_sec_i<UNIT, load all three fields and clear the prescaler. Otherwise leave state untouched and pulse set_err_o. Load has priority over a simultaneous advance, and that advance is discarded. A load never raises tick_o, day_o or alarm_o.
- Alarm capture: alm_set_i latches alm_hr_i/alm_min_i. Out-of-range values are latched as given and never match. Capture is independent of set_i; both may occur in the same cycle.
- Alarm: pulses when an advance produces sec==0, min==alarm min and hr==alarm hr, with alm_en_i=1 at that edge. It pulses once per day.
- Display mapping (combinational from state), 12-hour mode: hr 0 → 12 with pm_o=0; 1..11 → same value, pm_o=0; 12 → 12, pm_o=1; 13..DAY_HRS-1 → hr−12, pm_o=1. 24-hour mode: hour_o=hr, pm_o=0. mode12_i may change at any time and takes effect immediately.

## Timing
- Reset values: all counters 0, alarm registers 0; sec_o=min_o=0, pm_o=0, all strobes 0; hour_o=0 in 24-hour mode, 12 in 12-hour mode.
- First advance occurs on the FREQ-th rising edge with en_i=1 after reset release or after a load.
- tick_o, day_o and alarm_o are registered. They are high for the single cycle after the edge that updates the time, coincident with the new sec_o/min_o/hour_o.
- set_err_o is registered and high in the cycle after the rejected set_i.
- A load is visible on the outputs one cycle after set_i.
- Reset asserted mid-second clears the partial prescaler count.

## Structure
- Package rtc_pkg: the 12-hour offset constant, and a function giving the 12-hour display value and PM flag from hr.
- Sub-module mod_counter (parameters MOD and W; ports inc, load, ld_val, q, carry) instantiated for the prescaler and for sec, min and hr. Load validation, alarm compare and strobes live in the top level.

## Test plan
- Reset, en_i=1, FREQ=10: tick_o first at edge 10; sec_o=1. After 600 cycles, min_o=1, sec_o=0.
- Load 23:59:59 with en_i=1: after 10 cycles, outputs are 00:00:00 and day_o and tick_o pulse together. With mode12_i=1, hour_o=12, pm_o=0.
- set_i with set_min_i=60: set_err_o pulses; time unchanged. set_i coincident with an advance edge: loaded value wins and there is no tick_o.
- Alarm 07:30 with alm_en_i=1, load 07:29:59: alarm_o pulses once at 07:30:00. Same setup with alm_en_i=0: no pulse.
- en_i dropped for 25 cycles mid-second: sec_o and the prescaler hold, and the next tick is delayed by exactly 25 cycles.
- rst_n asserted mid-count at 13:05:42 in 12-hour mode (hour_o=1, pm_o=1): outputs return to reset values asynchronously.
